// File: rtl/i2c_target_regs_if.sv
// I2C pad-side bundle for the register target.
// Carries the raw SCL/SDA pad levels into the target and the open-drain
// SDA enable back out to an I2CBUF-style pad split.
//   scl_in : raw SCL level seen at the pad (asynchronous)
//   sda_in : raw SDA level seen at the pad (asynchronous)
//   sda_oe : 1 = pull SDA low, 0 = release
// master modport: the bus/pad side; slave modport: the target.
interface i2c_target_regs_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register file, answering at a fixed 7-bit address.
// Write transfers set a register pointer then auto-increment through the file;
// read transfers stream registers from the pointer. Registers are exposed in
// parallel to fabric logic and every bus write is reported by a strobe.
// Ports:
//   clk_50_max10 : system clock
//   fpga_reset   : synchronous reset, active-high
//   bus          : pad bundle (scl_in, sda_in in; sda_oe out)
//   reg_flat     : register file, reg k = reg_flat[8k+7:8k]
//   wr_stb       : one-cycle pulse per register written from the bus
//   wr_idx       : register index written, valid with wr_stb
//   wr_data      : byte written, valid with wr_stb
//   busy         : set from an address match until the next START/STOP
module i2c_target_regs #(
  parameter logic [6:0]  I2C_ADDR = 7'h48,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned FILT_LEN = 3,
  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   clk_50_max10,
  input  logic                   fpga_reset,
  i2c_target_regs_if.slave       bus,
  output logic [8*NUM_REGS-1:0]  reg_flat,
  output logic                   wr_stb,
  output logic [IW-1:0]          wr_idx,
  output logic [7:0]             wr_data,
  output logic                   busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK,
    ST_WR_PTR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_IGNORE
  } state_t;

  logic                scl_s1, scl_s2, sda_s1, sda_s2;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl_f, sda_f, scl_fp, sda_fp;

  state_t              state, ack_dst;
  logic                ack_drv;
  logic [3:0]          bit_cnt;
  logic [6:0]          rx_sh;
  logic [7:0]          tx_sh;
  logic [IW-1:0]       ptr;
  logic                sda_oe_q;

  logic                scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]          rx_byte;
  logic [IW-1:0]       ptr_inc;

  // Synchroniser plus glitch filter: a line only changes level after
  // FILT_LEN consecutive identical synchronised samples.
  always_ff @(posedge clk_50_max10) begin
    if (fpga_reset) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_fp   <= 1'b1;
      sda_fp   <= 1'b1;
    end else begin
      scl_s1   <= bus.scl_in;
      scl_s2   <= scl_s1;
      sda_s1   <= bus.sda_in;
      sda_s2   <= sda_s1;
      scl_hist <= FILT_LEN'({scl_hist, scl_s2});
      sda_hist <= FILT_LEN'({sda_hist, sda_s2});
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_fp   <= scl_f;
      sda_fp   <= sda_f;
    end
  end

  // Bus events from the filtered levels.
  assign scl_rise  =  scl_f & ~scl_fp;
  assign scl_fall  = ~scl_f &  scl_fp;
  assign start_det =  scl_f &  scl_fp &  sda_fp & ~sda_f;
  assign stop_det  =  scl_f &  scl_fp & ~sda_fp &  sda_f;

  // Byte completed on the 8th rise: the last bit is still in sda_f.
  assign rx_byte = {rx_sh, sda_f};
  assign ptr_inc = ptr + IW'(1);

  assign bus.sda_oe = sda_oe_q;

  // Protocol FSM; START/STOP take priority over any sampled SCL edge.
  always_ff @(posedge clk_50_max10) begin
    if (fpga_reset) begin
      state    <= ST_IDLE;
      ack_dst  <= ST_IDLE;
      ack_drv  <= 1'b0;
      bit_cnt  <= 4'd0;
      rx_sh    <= 7'd0;
      tx_sh    <= 8'd0;
      ptr      <= '0;
      sda_oe_q <= 1'b0;
      reg_flat <= '0;
      wr_stb   <= 1'b0;
      wr_idx   <= '0;
      wr_data  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= 4'd0;
        ack_drv  <= 1'b0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else if (stop_det) begin
        state    <= ST_IDLE;
        ack_drv  <= 1'b0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_IGNORE: ;

          ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
            if (scl_rise) begin
              rx_sh   <= {rx_sh[5:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                ack_drv <= 1'b0;
                state   <= ST_ACK;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == I2C_ADDR) begin
                    busy    <= 1'b1;
                    ack_dst <= rx_byte[0] ? ST_RD_DATA : ST_WR_PTR;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else if (state == ST_WR_PTR) begin
                  ptr     <= rx_byte[IW-1:0];
                  ack_dst <= ST_WR_DATA;
                end else begin
                  reg_flat[{ptr, 3'b000} +: 8] <= rx_byte;
                  wr_stb  <= 1'b1;
                  wr_idx  <= ptr;
                  wr_data <= rx_byte;
                  ptr     <= ptr_inc;
                  ack_dst <= ST_WR_DATA;
                end
              end
            end
          end

          // First fall after the 8th bit pulls SDA; the next fall releases it.
          ST_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                ack_drv  <= 1'b1;
                sda_oe_q <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= ack_dst;
                if (ack_dst == ST_RD_DATA) begin
                  tx_sh    <= reg_flat[{ptr, 3'b000} +: 8];
                  sda_oe_q <= ~reg_flat[{ptr, 3'b111}];
                end else begin
                  sda_oe_q <= 1'b0;
                end
              end
            end
          end

          // bit_cnt counts rises of the current byte; the MSB is already on
          // the line when the byte starts, later bits follow each fall.
          ST_RD_DATA: begin
            if (scl_rise) begin
              if (bit_cnt == 4'd8) begin
                if (!sda_f) begin
                  ptr     <= ptr_inc;
                  tx_sh   <= reg_flat[{ptr_inc, 3'b000} +: 8];
                  bit_cnt <= 4'd0;
                end else begin
                  state <= ST_IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else if (scl_fall) begin
              if (bit_cnt < 4'd8) begin
                sda_oe_q <= ~tx_sh[3'(4'd7 - bit_cnt)];
              end else begin
                sda_oe_q <= 1'b0;
              end
            end
          end

          default: begin
            state    <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C initiator drives the
// pad bundle through a wired-AND SDA model and checks ACKs, read data,
// register contents and write strobes against hand-computed values.
module tb_i2c_target_regs;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned IW       = 4;
  localparam int unsigned Q        = 16;  // clocks per quarter SCL period

  logic                  clk_50_max10 = 1'b0;
  logic                  fpga_reset;
  logic                  scl_m, sda_m;
  logic [8*NUM_REGS-1:0] reg_flat;
  logic                  wr_stb;
  logic [IW-1:0]         wr_idx;
  logic [7:0]            wr_data;
  logic                  busy;

  int                    n_vec = 0;
  int                    n_err = 0;
  int                    stb_cnt = 0;
  logic [IW-1:0]         stb_idx = '0;
  logic [7:0]            stb_data = 8'd0;

  i2c_target_regs_if bus ();

  // Open-drain SDA: either side can pull low.
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_target_regs #(
    .I2C_ADDR (7'h48),
    .NUM_REGS (NUM_REGS),
    .FILT_LEN (3)
  ) u_dut (
    .clk_50_max10 (clk_50_max10),
    .fpga_reset   (fpga_reset),
    .bus          (bus),
    .reg_flat     (reg_flat),
    .wr_stb       (wr_stb),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .busy         (busy)
  );

  always #10 clk_50_max10 = ~clk_50_max10;

  always @(posedge clk_50_max10) begin
    if (wr_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_idx  <= wr_idx;
      stb_data <= wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk_50_max10);
  endtask

  function automatic logic [7:0] reg_at(input int k);
    return reg_flat[8*k +: 8];
  endfunction

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  // One SCL period; optional one-clock SCL glitch while SCL is low.
  task automatic i2c_bit(input logic b, input logic glitch, output logic r);
    sda_m = b;
    if (glitch) begin
      wait_clk(Q/2);
      scl_m = 1'b1; wait_clk(1);
      scl_m = 1'b0; wait_clk(Q/2 - 1);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b1; wait_clk(Q);
    r = bus.sda_in;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic glitch, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], glitch && (i == 4), r);
    i2c_bit(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, 1'b0, r);
      b[i] = r;
    end
    i2c_bit(nack, 1'b0, r);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic       r;

    fpga_reset = 1'b1;
    scl_m      = 1'b1;
    sda_m      = 1'b1;
    wait_clk(5);
    fpga_reset = 1'b0;
    wait_clk(5);

    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_regs",   32'(|reg_flat),  32'd0);
    chk("rst_wr_stb", 32'(wr_stb),     32'd0);

    // Write 0xA5 to reg 3.
    i2c_start();
    wr_byte(8'h90, 1'b0, ack); chk("w1_addr_ack", 32'(ack), 32'd0);
    chk("w1_busy", 32'(busy), 32'd1);
    wr_byte(8'h03, 1'b0, ack); chk("w1_ptr_ack",  32'(ack), 32'd0);
    wr_byte(8'hA5, 1'b0, ack); chk("w1_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(Q);
    chk("w1_reg3",     32'(reg_at(3)), 32'hA5);
    chk("w1_stb_cnt",  32'(stb_cnt),   32'd1);
    chk("w1_stb_idx",  32'(stb_idx),   32'd3);
    chk("w1_stb_data", 32'(stb_data),  32'hA5);
    chk("w1_busy_end", 32'(busy),      32'd0);

    // Set pointer 3, repeated START, read two bytes.
    i2c_start();
    wr_byte(8'h90, 1'b0, ack); chk("r1_waddr_ack", 32'(ack), 32'd0);
    wr_byte(8'h03, 1'b0, ack); chk("r1_ptr_ack",   32'(ack), 32'd0);
    i2c_start();
    wr_byte(8'h91, 1'b0, ack); chk("r1_raddr_ack", 32'(ack), 32'd0);
    rd_byte(1'b0, rd); chk("r1_byte0", 32'(rd), 32'hA5);
    rd_byte(1'b1, rd); chk("r1_byte1", 32'(rd), 32'h00);
    chk("r1_sda_rel", 32'(bus.sda_oe), 32'd0);
    i2c_stop();
    wait_clk(Q);
    chk("r1_stb_cnt", 32'(stb_cnt), 32'd1);

    // Address mismatch.
    i2c_start();
    wr_byte(8'h92, 1'b0, ack); chk("mm_nack", 32'(ack), 32'd1);
    chk("mm_busy", 32'(busy), 32'd0);
    i2c_stop();
    wait_clk(Q);
    chk("mm_reg3",    32'(reg_at(3)), 32'hA5);
    chk("mm_stb_cnt", 32'(stb_cnt),   32'd1);

    // Burst write across the pointer wrap.
    i2c_start();
    wr_byte(8'h90, 1'b0, ack); chk("bw_addr_ack", 32'(ack), 32'd0);
    wr_byte(8'h0F, 1'b0, ack); chk("bw_ptr_ack",  32'(ack), 32'd0);
    wr_byte(8'h11, 1'b0, ack); chk("bw_d0_ack",   32'(ack), 32'd0);
    wr_byte(8'h22, 1'b0, ack); chk("bw_d1_ack",   32'(ack), 32'd0);
    i2c_stop();
    wait_clk(Q);
    chk("bw_reg15",    32'(reg_at(15)), 32'h11);
    chk("bw_reg0",     32'(reg_at(0)),  32'h22);
    chk("bw_stb_cnt",  32'(stb_cnt),    32'd3);
    chk("bw_stb_idx",  32'(stb_idx),    32'd0);
    chk("bw_stb_data", 32'(stb_data),   32'h22);

    // One-clock SCL glitch inside a data byte.
    i2c_start();
    wr_byte(8'h90, 1'b0, ack); chk("gl_addr_ack", 32'(ack), 32'd0);
    wr_byte(8'h05, 1'b0, ack); chk("gl_ptr_ack",  32'(ack), 32'd0);
    wr_byte(8'h5A, 1'b1, ack); chk("gl_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(Q);
    chk("gl_reg5",    32'(reg_at(5)), 32'h5A);
    chk("gl_stb_cnt", 32'(stb_cnt),   32'd4);

    // Reset while the target is driving the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      rd = 8'h90;
      i2c_bit(rd[i], 1'b0, r);
    end
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q/2);
    chk("rs_ack_drv", 32'(bus.sda_oe), 32'd1);
    fpga_reset = 1'b1;
    wait_clk(1);
    chk("rs_sda_rel", 32'(bus.sda_oe), 32'd0);
    chk("rs_regs",    32'(|reg_flat),  32'd0);
    chk("rs_busy",    32'(busy),       32'd0);
    fpga_reset = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
    i2c_stop();
    wait_clk(Q);

    // Target still operational after the mid-transfer reset.
    i2c_start();
    wr_byte(8'h90, 1'b0, ack); chk("pr_addr_ack", 32'(ack), 32'd0);
    wr_byte(8'h01, 1'b0, ack); chk("pr_ptr_ack",  32'(ack), 32'd0);
    wr_byte(8'h77, 1'b0, ack); chk("pr_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(Q);
    chk("pr_reg1", 32'(reg_at(1)), 32'h77);
    chk("pr_reg3", 32'(reg_at(3)), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
